// File: rtl/seg_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seg_pkg : shared constants and types for the 4-digit scan multiplexer
// Rev 1.0
// ----------------------------------------------------------------------------
package seg_pkg;

  localparam int NUM_DIGITS = 4;
  localparam logic [NUM_DIGITS-1:0] EN_ALL_OFF = 4'b1111;

  typedef logic [1:0] digit_idx_t;

  localparam digit_idx_t LAST_DIGIT = 2'd3;

endpackage
`default_nettype wire

// File: rtl/seg_scan_mux_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seg_scan_mux_if : value load / display drive bundle of the scan multiplexer
// Rev 1.0
// ----------------------------------------------------------------------------
interface seg_scan_mux_if;

  logic                            load;
  logic [15:0]                     value;
  logic                            lzs;
  logic [3:0]                      nibble;
  logic [seg_pkg::NUM_DIGITS-1:0]  en;
  logic                            frame_done;

  modport master (
    output load, value, lzs,
    input  nibble, en, frame_done
  );

  modport slave (
    input  load, value, lzs,
    output nibble, en, frame_done
  );

endinterface
`default_nettype wire

// File: rtl/seg_prescaler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seg_prescaler : free-running 0..REFRESH_DIV-1 slot counter with wrap tick
// Rev 1.0
// ----------------------------------------------------------------------------
module seg_prescaler #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = $clog2(REFRESH_DIV)
) (
  input  wire logic             clk,
  input  wire logic             rst,
  output logic      [CNT_W-1:0] cnt,
  output logic                  tick
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    tick  = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule
`default_nettype wire

// File: rtl/seg_scan_mux.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seg_scan_mux : 4-digit hex display scanner with frame-synchronous update,
//                anti-ghost guard interval and leading-zero suppression
// Rev 1.0
// ----------------------------------------------------------------------------
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 1000
) (
  input  wire logic      clk,
  input  wire logic      rst,
  seg_scan_mux_if.slave  bus
);

  localparam int CNT_W = $clog2(REFRESH_DIV);

  logic [CNT_W-1:0] cnt;
  logic             tick;

  seg_prescaler #(
    .REFRESH_DIV (REFRESH_DIV),
    .CNT_W       (CNT_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .cnt  (cnt),
    .tick (tick)
  );

  digit_idx_t  idx_q, idx_d;
  logic [15:0] shadow_q, shadow_d;
  logic [15:0] disp_q, disp_d;
  logic        pending_q, pending_d;
  logic        frame_done_q, frame_done_d;
  logic        wrap;

  always_comb begin
    wrap         = tick && (idx_q == LAST_DIGIT);
    idx_d        = tick ? digit_idx_t'(idx_q + 2'd1) : idx_q;
    shadow_d     = shadow_q;
    disp_d       = disp_q;
    pending_d    = pending_q;
    frame_done_d = wrap;
    if (wrap && pending_q) begin
      disp_d    = shadow_q;
      pending_d = 1'b0;
    end
    // A load on the wrap tick lands after the transfer above, so it stays pending.
    if (bus.load) begin
      shadow_d  = bus.value;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q        <= '0;
      shadow_q     <= '0;
      disp_q       <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      disp_q       <= disp_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
    end
  end

  logic                  in_guard;
  logic [NUM_DIGITS-1:0] blank;
  logic [NUM_DIGITS-1:0] en_n;

  always_comb begin
    in_guard = (cnt < CNT_W'(GUARD));
    // A digit is blanked only when it and every more-significant digit are zero.
    blank[3] = bus.lzs && (disp_q[15:12] == 4'h0);
    blank[2] = blank[3] && (disp_q[11:8] == 4'h0);
    blank[1] = blank[2] && (disp_q[7:4] == 4'h0);
    blank[0] = 1'b0;
    en_n     = EN_ALL_OFF;
    if (!rst && !in_guard && !blank[idx_q]) en_n[idx_q] = 1'b0;
  end

  assign bus.en         = en_n;
  assign bus.nibble     = disp_q[{idx_q, 2'b00} +: 4];
  assign bus.frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_mux.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_seg_scan_mux : vector table, directed corner sequences and random traffic
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_seg_scan_mux;

  localparam int DIV   = 4;
  localparam int GRD   = 1;
  localparam int FRAME = 4 * DIV;

  logic clk;
  logic rst;

  seg_scan_mux_if bus ();

  seg_scan_mux #(
    .REFRESH_DIV (DIV),
    .GUARD       (GRD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: t = cycles since the last reset edge; slot/digit follow by division.
  int          m_t;
  logic [15:0] m_disp, m_shadow;
  logic        m_pend, m_fd;
  bit          m_valid = 0;

  logic [3:0]  s_en, s_nib;
  logic        s_fd;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0d", name, act, exp, m_t);
    end
  endtask

  function automatic logic [3:0] model_en(input logic r, input logic z);
    int          d;
    logic [3:0]  e;
    d = (m_t / DIV) % 4;
    e = 4'b1111;
    if (!r && (m_t % DIV) >= GRD && !(z && d > 0 && (m_disp >> (4 * d)) == 16'h0))
      e[d] = 1'b0;
    return e;
  endfunction

  function automatic logic [3:0] model_nib();
    int d;
    d = (m_t / DIV) % 4;
    return 4'((m_disp >> (4 * d)) & 16'hF);
  endfunction

  task automatic step(input logic r, input logic l, input logic [15:0] v, input logic z);
    bit wrap;
    rst       = r;
    bus.load  = l;
    bus.value = v;
    bus.lzs   = z;
    @(negedge clk);
    s_en  = bus.en;
    s_nib = bus.nibble;
    s_fd  = bus.frame_done;
    if (m_valid) begin
      chk("model_en", 16'(s_en), 16'(model_en(r, z)));
      chk("model_nibble", 16'(s_nib), 16'(model_nib()));
      chk("model_frame_done", 16'(s_fd), 16'(m_fd));
    end
    @(posedge clk);
    if (r) begin
      m_t = 0; m_disp = '0; m_shadow = '0; m_pend = 0; m_fd = 0;
      m_valid = 1;
    end else begin
      wrap = (m_t % FRAME) == FRAME - 1;
      m_fd = wrap;
      if (wrap && m_pend) begin m_disp = m_shadow; m_pend = 0; end
      if (l) begin m_shadow = v; m_pend = 1; end
      m_t++;
    end
    #1;
  endtask

  task automatic reset_dut();
    step(1, 0, 16'h0, 0);
    step(1, 0, 16'h0, 0);
  endtask

  typedef struct {
    logic        r;
    logic        l;
    logic [15:0] v;
    logic        z;
    logic [3:0]  en;
    logic [3:0]  nib;
    logic        fd;
  } vec_t;

  vec_t        tbl [19];
  logic [3:0]  digs [4];
  logic [15:0] fdcnt;
  logic [3:0]  e;
  int          d, p;
  bit          lit;

  initial begin
    rst = 1'b1; bus.load = 1'b0; bus.value = '0; bus.lzs = 1'b0;

    // Reset release with no load: guard then rotate 0,1,2,3.
    tbl[0] = '{1'b1, 1'b0, 16'h0, 1'b0, 4'b1111, 4'h0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 16'h0, 1'b0, 4'b1111, 4'h0, 1'b0};
    for (int k = 2; k < 17; k++) begin
      p = (k - 1) % 4;
      d = (k - 1) / 4;
      e = 4'b1111;
      if (p != 0) e[d] = 1'b0;
      tbl[k] = '{1'b0, 1'b0, 16'h0, 1'b0, e, 4'h0, 1'b0};
    end
    tbl[17] = '{1'b0, 1'b0, 16'h0, 1'b0, 4'b1111, 4'h0, 1'b1};
    tbl[18] = '{1'b0, 1'b0, 16'h0, 1'b0, 4'b1110, 4'h0, 1'b0};

    step(1, 0, 16'h0, 0);
    for (int k = 0; k < 19; k++) begin
      step(tbl[k].r, tbl[k].l, tbl[k].v, tbl[k].z);
      chk("tbl_en", 16'(s_en), 16'(tbl[k].en));
      chk("tbl_nibble", 16'(s_nib), 16'(tbl[k].nib));
      chk("tbl_frame_done", 16'(s_fd), 16'(tbl[k].fd));
    end

    // Mid-frame load shows only from the next frame, digit order F,A,2,1.
    digs[0] = 4'hF; digs[1] = 4'hA; digs[2] = 4'h2; digs[3] = 4'h1;
    reset_dut();
    fdcnt = '0;
    for (int k = 0; k < 48; k++) begin
      step(0, k == 5, 16'h12AF, 0);
      if (k < 16) chk("sync_pre_nibble", 16'(s_nib), 16'h0);
      else        chk("sync_nibble", 16'(s_nib), 16'(digs[(k / 4) % 4]));
      fdcnt = fdcnt + 16'(s_fd);
    end
    chk("sync_frame_done_count", fdcnt, 16'd2);

    // Two loads in one frame: last value wins.
    reset_dut();
    for (int k = 0; k < 48; k++) begin
      step(0, k == 3 || k == 8, (k == 3) ? 16'h1111 : 16'h2222, 0);
      chk("double_nibble", 16'(s_nib), (k < 16) ? 16'h0 : 16'h2);
    end

    // Load on the wrap tick while 3333 is pending.
    reset_dut();
    for (int k = 0; k < 48; k++) begin
      step(0, k == 5 || k == 15, (k == 5) ? 16'h3333 : 16'h5555, 0);
      chk("wrap_load_nibble", 16'(s_nib), (k < 16) ? 16'h0 : (k < 32) ? 16'h3 : 16'h5);
    end

    // Leading-zero suppression on 0000 then 0050.
    reset_dut();
    for (int k = 0; k < 32; k++) begin
      step(0, k == 2, 16'h0050, 1);
      p   = k % 4;
      d   = (k / 4) % 4;
      lit = (k < 16) ? (d == 0) : (d <= 1);
      e   = 4'b1111;
      if (p != 0 && lit) e[d] = 1'b0;
      chk("lzs_en", 16'(s_en), 16'(e));
      if (k >= 16) chk("lzs_nibble", 16'(s_nib), (d == 1) ? 16'h5 : 16'h0);
    end

    // Reset in a digit-2 slot with a value pending discards it.
    reset_dut();
    for (int k = 0; k < 41; k++) step(0, k == 1 || k == 20, (k == 1) ? 16'hABCD : 16'h1234, 0);
    step(1, 0, 16'h0, 0);
    chk("rst_en_first", 16'(s_en), 16'hF);
    step(1, 0, 16'h0, 0);
    chk("rst_en_held", 16'(s_en), 16'hF);
    for (int k = 0; k < 40; k++) begin
      step(0, 0, 16'h0, 0);
      chk("rst_discard_nibble", 16'(s_nib), 16'h0);
    end

    // Random traffic against the reference.
    for (int k = 0; k < 3000; k++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0,
           16'($urandom), 1'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg_scan_mux.md
SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clock cycles per digit slot (minimum 4).
REQ-002 Parameter GUARD, default 1000, cycles at start of each slot with all anodes off for anti-ghosting (0 <= GUARD < REFRESH_DIV).
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge system clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 load  input  1  single-cycle strobe; capture value into shadow register.
REQ-007 value  input  16  four hex digits; [3:0] = digit 0 (rightmost), [15:12] = digit 3.
REQ-008 lzs  input  1  leading-zero suppression enable; sampled every cycle.
REQ-009 nibble  output  4  hex code of the active digit, driven to the downstream 7-segment decoder inputs {s3,s2,s1,s0}.
REQ-010 en  output  4  active-low anode enables (0 = glow); en[i] drives digit i.
REQ-011 frame_done  output  1  one-cycle pulse at each frame wrap.

Function
REQ-012 Prescaler cnt SHALL count 0..REFRESH_DIV-1 and wrap to 0; tick is asserted when cnt == REFRESH_DIV-1.
REQ-013 Digit index idx (2 bits) SHALL advance on tick: 0->1->2->3->0.
REQ-014 On load, shadow <= value and pending <= 1; a later load before application overwrites shadow (last value wins).
REQ-015 On tick with idx == 3 and pending == 1: disp <= shadow, pending <= 0, so a new value is always shown from digit 0 of a fresh frame (no tearing).
REQ-016 If load coincides with the frame-wrap tick, the old shadow transfers to disp, the new value is captured into shadow, and pending remains 1.
REQ-017 frame_done SHALL be registered, high for exactly the one cycle after the tick that moves idx 3->0.
REQ-018 nibble SHALL equal disp[4*idx+3 : 4*idx], decoded combinationally from registered idx and disp only.
REQ-019 en SHALL be 4'b1111 while cnt < GUARD; otherwise bit idx low and all other bits high, unless the digit is blanked.
REQ-020 Blanking: with lzs = 1, digit i (i = 3,2,1) SHALL be blanked (en all ones) when disp nibbles i..3 are all zero; digit 0 is never blanked.
REQ-021 en SHALL never have more than one bit low in any cycle.

Reset
REQ-022 When rst is high at a clock edge: cnt = 0, idx = 0, disp = 0, shadow = 0, pending = 0, frame_done = 0.
REQ-023 While rst is high, en SHALL be 4'b1111.
REQ-024 In the first cycle after rst deasserts, the slot restarts at digit 0, and en stays 4'b1111 for GUARD cycles.
REQ-025 Reset during a slot, or with a load pending, SHALL discard the pending value.

Structure
REQ-026 The shared package seg_pkg SHALL hold the digit count constant (4), the all-off anode constant 4'b1111, and the digit-index typedef.
REQ-027 One sub-module is natural: seg_prescaler (counter plus tick output, parameterised by REFRESH_DIV).
REQ-028 Remaining logic (shadow/pending/disp registers, idx, blanking, en/nibble mux) SHALL stay in seg_scan_mux.
REQ-029 seg_scan_mux SHALL contain no segment decoding; nibble feeds the existing decoder.

Verification (REFRESH_DIV=4, GUARD=1)
REQ-030 Reset release, no load -> en sequence per slot 1111,1110,1110,1110 with idx 0; digits rotate 1101, 1011, 0111; nibble = 0.
REQ-031 Frame-sync load: load with value=16'h12AF mid-frame -> disp unchanged until the 3->0 tick; then nibble = F,A,2,1 for digits 0..3; frame_done pulses once per 16 cycles.
REQ-032 Double load: loads of 16'h1111 then 16'h2222 in the same frame -> only 16'h2222 is ever displayed.
REQ-033 Load on the wrap tick: load 16'h5555 in the tick cycle while shadow = 16'h3333 is pending -> frame shows 3333, next frame shows 5555.
REQ-034 LZS: disp = 16'h0050 with lzs = 1 -> digits 3 and 2 show en = 1111 all slot; digit 1 shows 5; digit 0 shows 0. disp = 16'h0000 -> only digit 0 lit.
REQ-035 Mid-operation reset: rst asserted during a digit-2 slot with pending = 1 -> en = 1111; after release disp = 0 and the pending value is never shown.
